// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-unit parameter defaults, fetch state and next-PC select encodings.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS_DEF = 32'd4096;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  // Word-aligned and inside [base, limit); limit is 33 bits so base+size cannot wrap.
  function automatic logic fetch_legal(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] limit);
    logic [32:0] addr_ext;
    addr_ext = {1'b0, addr};
    return (addr[1:0] == 2'b00) && (addr_ext >= {1'b0, base}) && (addr_ext < limit);
  endfunction

endpackage

// File: rtl/npc_select.sv
// Combinational next-PC candidate mux (jr > j > branch > sequential) with fetch legality check.
module npc_select
  import cpu_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] cand,
  output logic        legal
);

  localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  npc_sel_e sel_s;

  // Resolve the redirect priority into a select code.
  always_comb begin
    sel_s = NPC_SEQ;
    if (jump_reg) begin
      sel_s = NPC_JR;
    end else if (jump) begin
      sel_s = NPC_J;
    end else if (branch_taken) begin
      sel_s = NPC_BR;
    end else begin
      sel_s = NPC_SEQ;
    end
  end

  // Candidate mux and legality flag.
  always_comb begin
    cand = pc_plus4;
    case (sel_s)
      NPC_JR:  cand = reg_target;
      NPC_J:   cand = {pc_plus4[31:28], jump_index, 2'b00};
      NPC_BR:  cand = branch_target;
      NPC_SEQ: cand = pc_plus4;
      default: cand = pc_plus4;
    endcase
    legal = fetch_legal(cand, IMEM_BASE, IMEM_LIMIT);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter owner: next-PC update, trap entry/return through epc, retired-instruction count.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap_active,
  output logic [31:0] epc,
  output logic [31:0] badvaddr,
  output logic [31:0] instr_count
);

  state_e      state_r, state_nx_s;
  logic [31:0] pc_r, pc_nx_s;
  logic [31:0] epc_r, epc_nx_s;
  logic [31:0] bad_r, bad_nx_s;
  logic [31:0] cnt_r, cnt_nx_s;
  logic [31:0] cand_s;
  logic        legal_s;

  assign pc_plus4 = pc_r + 32'd4;

  npc_select #(
    .IMEM_BASE (IMEM_BASE),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_npc_select (
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .cand         (cand_s),
    .legal        (legal_s)
  );

  // Next-state: eret in TRAP wins, then legal redirect, otherwise take (or re-take) the trap.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    epc_nx_s   = epc_r;
    bad_nx_s   = bad_r;
    cnt_nx_s   = cnt_r;
    if (en) begin
      if ((state_r == TRAP) && eret) begin
        pc_nx_s    = epc_r + 32'd4;
        state_nx_s = RUN;
        cnt_nx_s   = cnt_r + 32'd1;
      end else if (legal_s) begin
        pc_nx_s  = cand_s;
        cnt_nx_s = cnt_r + 32'd1;
      end else begin
        pc_nx_s    = HANDLER_PC;
        epc_nx_s   = pc_r;
        bad_nx_s   = cand_s;
        state_nx_s = TRAP;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // State and architectural registers; reset overrides stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      epc_r   <= 32'd0;
      bad_r   <= 32'd0;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      epc_r   <= epc_nx_s;
      bad_r   <= bad_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  assign pc          = pc_r;
  assign trap_active = (state_r == TRAP);
  assign epc         = epc_r;
  assign badvaddr    = bad_r;
  assign instr_count = cnt_r;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter owner for the single-cycle CPU.
- Holds PC and produces pc_plus4 for the branch-target adder.
- Consumes that adder's branch target, the j/jal index and the jr register target, and selects the next PC.
- Traps misaligned or out-of-range fetch targets into a handler state, resumes on eret, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, instruction memory size in words; legal range is [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS).
- HANDLER_PC, 32'h0000_4180, trap handler entry; this address is always legal.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- en  input  1  advance enable; 0 = hold every register (stall)
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  32  pc_plus4 + (sign-extended offset << 2), from the branch adder
- jump  input  1  j/jal
- jump_index  input  26  instr[25:0]
- jump_reg  input  1  jr/jalr
- reg_target  input  32  GPR[rs]
- eret  input  1  return from trap
- pc  output  32  current fetch address
- pc_plus4  output  32  pc + 4, combinational
- trap_active  output  1  1 while in TRAP state
- epc  output  32  address of the faulting redirect instruction
- badvaddr  output  32  offending target address
- instr_count  output  32  retired-instruction counter

Behaviour:
Reset (synchronous, clk edge with reset=1):
- pc=RESET_PC, state=RUN, epc=0, badvaddr=0, instr_count=0, trap_active=0.
- Reset overrides en and every other input, in any state.

Combinational outputs:
- pc_plus4 = pc + 32'd4, wrapping modulo 2^32.
- jump target = {pc_plus4[31:28], jump_index, 2'b00}.

Candidate next PC, fixed priority:
- jump_reg selects reg_target.
- else jump selects the jump target.
- else branch_taken selects branch_target.
- else pc_plus4.
- Multiple selects asserted in one cycle is legal; the priority resolves it, no error.

Legality: candidate is legal iff cand[1:0]==0 and IMEM_BASE <= cand < IMEM_BASE+4*IMEM_WORDS. Use unsigned 33-bit comparison so the upper bound cannot overflow.

State RUN, with en=1:
- Legal candidate: pc<=cand; instr_count<=instr_count+1, wrapping.
- Illegal candidate: pc<=HANDLER_PC, epc<=pc, badvaddr<=cand, state<=TRAP. instr_count unchanged, since the faulting instruction does not retire.
- eret in RUN is ignored and treated as sequential.

State TRAP, with en=1:
- trap_active=1 and the handler runs normally, using the same next-PC rules. instr_count increments.
- eret=1: pc<=epc+4, state<=RUN, instr_count+1. eret beats all redirect inputs.
- Illegal candidate inside TRAP (nested fault): pc<=HANDLER_PC, epc and badvaddr overwritten, state stays TRAP.
- epc+4 is not legality-checked; epc was a legal PC.

en=0: every register holds, including state and counter. Inputs that cycle are discarded.

Latency:
- Redirects take effect at the next rising edge; no delay slot.
- pc_plus4 follows pc with zero cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC, HANDLER_PC, IMEM_BASE and IMEM_WORDS defaults.
  - state enum {RUN, TRAP}.
  - an npc_sel_e enum {NPC_SEQ, NPC_BR, NPC_J, NPC_JR}, also used by the controller.
- One natural sub-module, npc_select: purely combinational. It takes pc_plus4, the targets and the selects, and outputs cand plus a legal flag.
- Sequential state, the counter and the trap registers live in the top module.

Test Plan:
1. Reset and run: reset 1 cycle, en=1, no redirects, 3 cycles -> pc=0x3000,0x3004,0x3008,0x300C; instr_count=3.
2. Branch: at pc=0x3010, branch_taken=1, branch_target=0x3040 -> pc=0x3040. Same cycle with jump=1, jump_index=0x0000C20 -> jump wins, pc=0x3080.
3. Jr fault: at pc=0x3020, jump_reg=1, reg_target=0x3022 -> pc=0x4180, trap_active=1, epc=0x3020, badvaddr=0x3022, count unchanged.
   - Later eret=1 -> pc=0x3024, trap_active=0.
4. Range fault: at pc=0x3000, branch_taken=1, branch_target=0x7000 (IMEM_WORDS=4096 puts the upper bound at exactly 0x7000, so it is out of range) -> trap, badvaddr=0x7000.
   - branch_target=0x6FFC -> legal, pc=0x6FFC.
5. Stall: en=0 for 4 cycles with branch_taken=1 -> pc and instr_count frozen. en=1 again with no redirect -> pc advances by 4.
6. Reset mid-trap: in TRAP with eret=1 and reset=1 on the same edge -> pc=0x3000, state RUN, epc=0, instr_count=0.
